// File: rtl/fir_channel_scheduler.sv
// Time-multiplexed decimating FIR: round-robin over CHANNELS input FIFOs,
// one shared MAC, per-channel sample history, results to per-channel output FIFOs.
module fir_channel_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 2,
  parameter int TAPS       = 32,
  parameter int DECIMATION = 8,
  parameter logic [DATA_WIDTH-1:0] COEFF [TAPS] = '{
    -1, -2, -3, -4, -3,  0,  5, 12, 20, 29, 38, 47, 55, 61, 66, 68,
    68, 66, 61, 55, 47, 38, 29, 20, 12,  5,  0, -3, -4, -3, -2, -1
  }
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CHANNELS*DATA_WIDTH-1:0] x_in,
  output logic [CHANNELS-1:0]            x_in_rd_en,
  input  logic [CHANNELS-1:0]            x_in_empty,
  output logic [DATA_WIDTH-1:0]          y_out,
  output logic [CHANNELS-1:0]            y_out_wr_en,
  input  logic [CHANNELS-1:0]            y_out_full
);

  localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, READ, COMPUTE, WRITE} state_t;

  state_t                        state, state_next;
  logic [GW-1:0]                 grant, rr_ptr, pick, cand;
  logic                          found;
  logic [CW-1:0]                 count;
  logic signed [DATA_WIDTH-1:0]  acc, acc_next;
  logic [DATA_WIDTH-1:0]         hist [CHANNELS][TAPS];
  logic [DATA_WIDTH-1:0]         sample;
  logic signed [DATA_WIDTH-1:0]  c_k, h_k;
  logic signed [PW-1:0]          prod, rnd;
  logic                          pop, last_pop, last_tap, wr_ok;

  // First non-empty channel starting at rr_ptr, wrapping modulo CHANNELS
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    cand  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cand = GW'((32'(rr_ptr) + i) % CHANNELS);
      if (!found && !x_in_empty[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    sample = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (grant == GW'(c)) sample = x_in[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Product rounded toward zero before the Q10 shift
  always_comb begin
    c_k      = COEFF[count];
    h_k      = hist[grant][count];
    prod     = PW'(c_k) * PW'(h_k);
    rnd      = prod[PW-1] ? prod + PW'(1023) : prod;
    acc_next = acc + DATA_WIDTH'(rnd >>> 10);
  end

  assign pop      = (state == READ) && !x_in_empty[grant];
  assign wr_ok    = (state == WRITE) && !y_out_full[grant];
  assign last_pop = pop && (count == CW'(DECIMATION - 1));
  assign last_tap = (count == CW'(TAPS - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found)    state_next = READ;
      READ:    if (last_pop) state_next = COMPUTE;
      COMPUTE: if (last_tap) state_next = WRITE;
      WRITE:   if (wr_ok)    state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  always_comb begin
    x_in_rd_en  = '0;
    y_out_wr_en = '0;
    if (!reset) begin
      if (pop)   x_in_rd_en[grant]  = 1'b1;
      if (wr_ok) y_out_wr_en[grant] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      grant  <= '0;
      rr_ptr <= '0;
      count  <= '0;
      acc    <= '0;
      y_out  <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        for (int unsigned k = 0; k < TAPS; k++) hist[c][k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= pick;
            count <= '0;
          end
        end
        READ: begin
          if (pop) begin
            for (int unsigned k = TAPS - 1; k > 0; k--) hist[grant][k] <= hist[grant][k-1];
            hist[grant][0] <= sample;
            if (last_pop) begin
              count <= '0;
              acc   <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        COMPUTE: begin
          acc <= acc_next;
          // Output register loads with the final sum so it is valid during the wr_en cycle
          if (last_tap) begin
            count <= '0;
            y_out <= acc_next;
          end else begin
            count <= count + 1'b1;
          end
        end
        WRITE: begin
          if (wr_ok) rr_ptr <= (grant == GW'(CHANNELS - 1)) ? '0 : grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Randomized bench for fir_channel_scheduler: FIFO models on every port and a
// transaction-level reference (arbitration order, per-channel FIR, output latency).
module tb_fir_channel_scheduler;

  localparam int DW   = 32;
  localparam int CH   = 2;
  localparam int TAPS = 32;
  localparam int DEC  = 8;
  localparam logic [31:0] TB_COEFF [32] = '{
    -1, -2, -3, -4, -3,  0,  5, 12, 20, 29, 38, 47, 55, 61, 66, 68,
    68, 66, 61, 55, 47, 38, 29, 20, 12,  5,  0, -3, -4, -3, -2, -1
  };

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [CH*DW-1:0]  x_in = '0;
  logic [CH-1:0]     x_in_rd_en;
  logic [CH-1:0]     x_in_empty = '1;
  logic [DW-1:0]     y_out;
  logic [CH-1:0]     y_out_wr_en;
  logic [CH-1:0]     y_out_full = '0;

  fir_channel_scheduler #(
    .DATA_WIDTH (DW),
    .CHANNELS   (CH),
    .TAPS       (TAPS),
    .DECIMATION (DEC),
    .COEFF      (TB_COEFF)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .x_in        (x_in),
    .x_in_rd_en  (x_in_rd_en),
    .x_in_empty  (x_in_empty),
    .y_out       (y_out),
    .y_out_wr_en (y_out_wr_en),
    .y_out_full  (y_out_full)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  int in_q [CH][$];
  bit force_empty [CH];
  bit force_full [CH];
  bit rand_on = 1'b0;

  int mh [CH][TAPS];
  int exp_q [CH][$];
  int wr_order [$];
  int last_y [CH];
  int rd_cnt [CH];
  int cyc = 0;
  int blk_pops = 0;
  int exp_grant = 0;
  int rr = 0;
  int due = 0;
  int last_wr_cyc = 0;
  bit busy = 1'b0;
  bit pend = 1'b0;
  logic [CH-1:0] rd, wr;
  logic [DW-1:0] yo;

  task automatic check(string tag, int got, int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int deq(longint p);
    if (p < 0) p = p + 1023;
    return int'(p >>> 10);
  endfunction

  function automatic int fir_ref(int c);
    int a = 0;
    for (int k = 0; k < TAPS; k++) a += deq(longint'($signed(TB_COEFF[k])) * longint'(mh[c][k]));
    return a;
  endfunction

  function automatic int rand_sample();
    case ($urandom_range(0, 3))
      0:       return int'($urandom());
      1:       return int'($urandom_range(0, 4095)) - 2048;
      2:       return ($urandom_range(0, 1) != 0) ? 1024 : -1024;
      default: return int'($urandom_range(0, 1 << 20)) - (1 << 19);
    endcase
  endfunction

  function automatic bit inputs_left();
    for (int c = 0; c < CH; c++) if (in_q[c].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int c = 0; c < CH; c++) begin
      x_in[c*DW +: DW] = (in_q[c].size() != 0) ? in_q[c][0] : 0;
      x_in_empty[c]    = (in_q[c].size() == 0) || force_empty[c];
      y_out_full[c]    = force_full[c];
    end
  endtask

  task automatic model_reset();
    rr = 0; busy = 1'b0; pend = 1'b0; blk_pops = 0;
    for (int c = 0; c < CH; c++) begin
      exp_q[c].delete();
      for (int k = 0; k < TAPS; k++) mh[c][k] = 0;
    end
  endtask

  task automatic step();
    bit found;
    bit was_reset;
    @(negedge clock);
    cyc++;
    rd = x_in_rd_en; wr = y_out_wr_en; yo = y_out;
    was_reset = reset;
    if (reset) begin
      check("rst_rd_en", int'(rd), 0);
      check("rst_wr_en", int'(wr), 0);
    end else if (!busy) begin
      if ((rd | wr) != 0) check("idle_quiet", int'({rd, wr}), 0);
      found = 1'b0;
      for (int i = 0; i < CH; i++) begin
        int c = (rr + i) % CH;
        if (!found && !x_in_empty[c]) begin
          found = 1'b1;
          exp_grant = c;
        end
      end
      if (found) begin busy = 1'b1; blk_pops = 0; end
    end else begin
      if (rd != 0) begin
        check("rd_legal", int'(((rd & x_in_empty) == 0) && $onehot(rd)), 1);
        check("rd_chan", int'(rd), 1 << exp_grant);
        check("pops_in_block", int'(blk_pops < DEC), 1);
        if (rd[exp_grant] && in_q[exp_grant].size() != 0) begin
          for (int k = TAPS - 1; k > 0; k--) mh[exp_grant][k] = mh[exp_grant][k-1];
          mh[exp_grant][0] = in_q[exp_grant][0];
          blk_pops++;
          if (blk_pops == DEC) begin
            exp_q[exp_grant].push_back(fir_ref(exp_grant));
            pend = 1'b1;
            due  = cyc + TAPS + 1;
          end
        end
      end
      if (wr != 0) begin
        check("wr_legal", int'(((wr & y_out_full) == 0) && $onehot(wr)), 1);
        check("wr_chan", int'(wr), 1 << exp_grant);
        check("wr_cycle", cyc, pend ? due : -1);
        check("exp_pending", exp_q[exp_grant].size(), 1);
        if (exp_q[exp_grant].size() != 0) check("y_out", $signed(yo), exp_q[exp_grant].pop_front());
        last_y[exp_grant] = $signed(yo);
        wr_order.push_back(exp_grant);
        last_wr_cyc = cyc;
        busy = 1'b0; pend = 1'b0; blk_pops = 0;
        rr = (exp_grant + 1) % CH;
      end else if (pend && cyc == due && y_out_full[exp_grant]) begin
        due++;
      end
    end
    @(posedge clock);
    #1;
    if (was_reset) model_reset();
    for (int c = 0; c < CH; c++) begin
      if (rd[c] && in_q[c].size() != 0) begin
        void'(in_q[c].pop_front());
        rd_cnt[c]++;
      end
      if (rand_on) begin
        force_empty[c] = ($urandom_range(0, 4) == 0);
        force_full[c]  = ($urandom_range(0, 3) == 0);
      end
    end
    drive();
  endtask

  task automatic drain(string tag, int budget);
    int n = 0;
    while ((inputs_left() || busy) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drained"}, int'(n < budget), 1);
  endtask

  task automatic push_block(int c, int first, int rest);
    in_q[c].push_back(first);
    for (int i = 1; i < DEC; i++) in_q[c].push_back(rest);
    drive();
  endtask

  task automatic do_reset(int cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
    step();
    check("y_after_reset", int'(yo), 0);
  endtask

  initial begin
    int n, t, d0, half_sum, rd1_before;

    for (int c = 0; c < CH; c++) begin
      force_empty[c] = 1'b0; force_full[c] = 1'b0; rd_cnt[c] = 0; last_y[c] = 0;
    end
    model_reset();
    drive();
    do_reset(3);

    // Impulse on channel 0: only COEFF[7] sees the sample
    rd1_before = rd_cnt[1];
    push_block(0, 1024, 0);
    drain("impulse", 300);
    check("impulse_y", last_y[0], 12);
    check("impulse_rd1", rd_cnt[1] - rd1_before, 0);

    // Reset at cycle 10 of COMPUTE discards everything, including history
    push_block(0, 1024, 1024);
    n = 0;
    while (!pend && n < 200) begin step(); n++; end
    check("midcomp_reached", int'(pend), 1);
    t = due - TAPS - 1;
    while (cyc < t + 9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("midcomp_y_zero", int'(yo), 0);
    push_block(0, 1024, 0);
    drain("impulse2", 300);
    check("impulse2_y", last_y[0], 12);

    // Rounding toward zero
    do_reset(1);
    push_block(0, -1, 0);
    drain("round_m1", 300);
    check("round_m1_y", last_y[0], 0);
    push_block(0, -1024, 0);
    drain("round_m1024", 300);
    check("round_m1024_y", last_y[0], -12);

    // Round-robin with both channels loaded
    do_reset(1);
    wr_order.delete();
    for (int c = 0; c < CH; c++) repeat (2 * DEC) in_q[c].push_back(1024);
    drive();
    drain("rr", 600);
    check("rr_count", wr_order.size(), 4);
    for (int i = 0; i < 4; i++) check("rr_order", (i < wr_order.size()) ? wr_order[i] : -1, i % 2);
    half_sum = 0;
    for (int k = 0; k < 16; k++) half_sum += $signed(TB_COEFF[k]);
    check("rr_ch0_2nd", last_y[0], half_sum);
    check("rr_ch1_2nd", last_y[1], half_sum);

    // Input stall after the third pop
    for (int i = 0; i < DEC; i++) in_q[0].push_back(rand_sample());
    drive();
    n = 0;
    while (blk_pops < 3 && n < 200) begin step(); n++; end
    check("stall_reached", blk_pops, 3);
    force_empty[0] = 1'b1;
    drive();
    repeat (5) step();
    check("stall_held", blk_pops, 3);
    force_empty[0] = 1'b0;
    drive();
    drain("stall_in", 300);

    // Output full for 10 cycles while channel 1 waits
    force_full[0] = 1'b1;
    for (int i = 0; i < DEC; i++) in_q[0].push_back(rand_sample());
    drive();
    n = 0;
    while (!(pend && exp_grant == 0) && n < 200) begin step(); n++; end
    check("full_reached", int'(pend), 1);
    d0 = due;
    for (int i = 0; i < DEC; i++) in_q[1].push_back(rand_sample());
    drive();
    while (cyc < d0 + 9) step();
    force_full[0] = 1'b0;
    drive();
    step();
    check("full_release_cyc", last_wr_cyc, d0 + 10);
    drain("full", 400);

    // Randomized traffic with random empty/full stalls
    rand_on = 1'b1;
    for (int b = 0; b < 24; b++) begin
      int c = $urandom_range(0, CH - 1);
      for (int i = 0; i < DEC; i++) in_q[c].push_back(rand_sample());
      repeat ($urandom_range(0, 30)) step();
    end
    drain("random", 8000);
    rand_on = 1'b0;
    for (int c = 0; c < CH; c++) begin force_empty[c] = 1'b0; force_full[c] = 1'b0; end
    drive();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
